interrupt_arbiter_defer_controller: RTL
=======================================

Name: interrupt_arbiter_defer_controller

Overview:
- Multi-channel successor to the single-line interrupt delayer in the pipeline's fetch control path.
- Latches edge-triggered interrupt requests per channel, applies a per-channel mask and picks the lowest-index eligible request.
- Defers injection while the fetch stage is mid-way through a multi-word (immediate-bearing) instruction or stalled.
- Issues a one-cycle interrupt pulse with a vector index, then waits for the pipeline's acknowledge before arbitrating again.

Parameters:
- NUM_IRQ, 4, number of interrupt request channels (1..16).
- IMM_WORDS, 1, number of extra fetch words that follow an instruction flagged by imm; sets the deferral length (1..7).
- VEC_W, 2, width of intr_vec; must satisfy 2^VEC_W >= NUM_IRQ.
- CNT_W, 3, width of the deferral counter; must hold IMM_WORDS.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- irq_in  input  NUM_IRQ  raw request lines, rising-edge sensitive
- irq_mask  input  NUM_IRQ  1 = channel masked (still latched, not eligible)
- imm  input  1  instruction currently in fetch is followed by IMM_WORDS immediate words
- stall  input  1  fetch stage stalled this cycle
- intr_ack  input  1  pipeline has entered the handler for the issued interrupt
- OUT_INTR  output  1  one-cycle interrupt injection pulse
- intr_vec  output  VEC_W  index of the issued channel, valid while OUT_INTR=1, held until next issue
- pending  output  NUM_IRQ  latched-request register
- busy  output  1  high in DEFER, FIRE and WAIT_ACK

Behaviour:
- Reset (rst=1 at a rising edge): pending=0, irq_prev=0, state=IDLE, counter=0, OUT_INTR=0, intr_vec=0, busy=0.
  - Reset has priority over every other event, including mid-DEFER and mid-WAIT_ACK.
  - A line already high on the first cycle after reset counts as an edge, because irq_prev resets to 0.
- Edge detect: edge[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle.
  - edge[i] sets pending[i], independent of mask and state.
- Eligibility: elig = pending & ~irq_mask. Winner = lowest set index of elig.
- States:
  - IDLE:
    - elig==0 -> stay.
    - elig!=0 and imm=0 and stall=0 -> FIRE.
    - elig!=0 and (imm=1 or stall=1) -> DEFER. Counter <= IMM_WORDS if imm=1, else 0.
  - DEFER:
    - stall=1 -> hold counter and state.
    - Else if counter!=0 -> counter--.
    - Else if imm=1 (a new multi-word instruction is starting) -> counter <= IMM_WORDS.
    - Else -> FIRE.
    - If elig drops to 0 while in DEFER (masked or cleared) -> IDLE.
  - FIRE (exactly one cycle):
    - OUT_INTR=1; intr_vec = winner captured on entry.
    - Clear pending[winner] at the end of the cycle.
    - -> WAIT_ACK.
  - WAIT_ACK:
    - OUT_INTR=0. Requests keep latching.
    - intr_ack=1 -> IDLE.
    - No timeout; the state persists until intr_ack.
- intr_ack outside WAIT_ACK is ignored.
- Simultaneous set/clear: if edge[winner] occurs in the FIRE cycle, the set wins and pending[winner] stays 1 (new event).
- Winner is frozen on FIRE entry. A higher-priority request arriving during DEFER does re-select the winner, since selection happens at FIRE entry.
- Latency: edge sampled at edge k with imm=stall=0 throughout -> OUT_INTR high in the cycle after edge k+1 (2 cycles).
- OUT_INTR, intr_vec and busy are registered and decoded from state; there are no combinational paths from inputs to outputs.

Test Plan:
- Single request: irq_in[2] rises at cycle 5, imm=stall=0 -> OUT_INTR=1 in cycle 7, intr_vec=2, pending[2] cleared; intr_ack at cycle 10 -> IDLE, busy=0 in cycle 11.
- Immediate deferral (IMM_WORDS=1): irq_in[0] rises while imm=1 -> DEFER; pulse delayed by exactly 2 cycles versus the no-imm case. Repeat with imm=1 on consecutive instructions and check the counter reloads.
- Priority and masking: irq_in[3] and irq_in[1] rise together, irq_mask=0010 -> vec=3 first. After ack and unmasking -> vec=1 with no new edge needed.
- Stall: stall=1 for 4 cycles during DEFER with counter=1 -> the counter holds. The pulse comes 2 cycles after stall drops, and exactly one pulse is issued.
- Re-trigger in FIRE: irq_in[0] edge coincides with the FIRE cycle for channel 0 -> pending[0]=1 after FIRE, and a second issue follows the next intr_ack.
- Reset mid-operation: rst=1 in WAIT_ACK with pending=1010 -> next cycle pending=0, OUT_INTR=0, busy=0. If irq_in[1] is held high through reset -> it is relatched and issued 2 cycles after reset release.

Source files
------------

// File: rtl/interrupt_arbiter_defer_controller_if.sv
// rtl/interrupt_arbiter_defer_controller_if.sv - request/handshake bundle between pipeline control and the interrupt arbiter
interface interrupt_arbiter_defer_controller_if #(
    parameter int NUM_IRQ = 4,
    parameter int VEC_W   = 2
) ();
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               imm;
    logic               stall;
    logic               intr_ack;
    logic               OUT_INTR;
    logic [VEC_W-1:0]   intr_vec;
    logic [NUM_IRQ-1:0] pending;
    logic               busy;

    modport master (
        output irq_in, irq_mask, imm, stall, intr_ack,
        input  OUT_INTR, intr_vec, pending, busy
    );

    modport slave (
        input  irq_in, irq_mask, imm, stall, intr_ack,
        output OUT_INTR, intr_vec, pending, busy
    );
endinterface

// File: rtl/interrupt_arbiter_defer_controller.sv
// rtl/interrupt_arbiter_defer_controller.sv - latches edge interrupts, picks lowest eligible channel, defers injection past multi-word fetches and stalls
module interrupt_arbiter_defer_controller #(
    parameter int NUM_IRQ   = 4,
    parameter int IMM_WORDS = 1,
    parameter int VEC_W     = 2,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    interrupt_arbiter_defer_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEFER    = 2'd1,
        S_FIRE     = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IMM_LOAD = CNT_W'(IMM_WORDS);

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [VEC_W-1:0]   r_vec;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_fire_entry;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_clr;
    logic [VEC_W-1:0]   w_winner;

    assign w_edge = bus.irq_in & ~r_irq_prev;
    assign w_elig = r_pending & ~bus.irq_mask;
    // Clear is applied before the OR so a fresh edge in the FIRE cycle survives.
    assign w_clr  = (r_state == S_FIRE) ? (NUM_IRQ'(1) << r_vec) : '0;

    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = VEC_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fire_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig != '0) begin
                    if (!bus.imm && !bus.stall) begin
                        w_state_next = S_FIRE;
                        w_fire_entry = 1'b1;
                    end else begin
                        w_state_next = S_DEFER;
                        w_cnt_next   = bus.imm ? IMM_LOAD : '0;
                    end
                end
            end
            S_DEFER: begin
                if (w_elig == '0) begin
                    w_state_next = S_IDLE;
                end else if (bus.stall) begin
                    w_cnt_next = r_cnt;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (bus.imm) begin
                    w_cnt_next = IMM_LOAD;
                end else begin
                    w_state_next = S_FIRE;
                    w_fire_entry = 1'b1;
                end
            end
            S_FIRE: begin
                w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.intr_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_irq_prev <= '0;
            r_cnt      <= '0;
            r_vec      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            r_irq_prev <= bus.irq_in;
            r_cnt      <= w_cnt_next;
            if (w_fire_entry) begin
                r_vec <= w_winner;
            end
        end
    end

    assign bus.OUT_INTR = (r_state == S_FIRE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.intr_vec = r_vec;
    assign bus.pending  = r_pending;
endmodule
